// File: rtl/axi_sram_fill_writer.sv
// axi_sram_fill_writer: command-driven AXI-Lite write master that fills a
// contiguous SRAM region with a constant or incrementing word, keeping up to
// MAX_OUTSTANDING writes in flight and reporting completion and bad responses.
// Optional statistics outputs (fill_cycles, bresp_errs) are built only when
// the macro AXI_SRAM_FILL_STATS_EN is defined.
module axi_sram_fill_writer #(
    parameter int AXI_ADDR_WIDTH  = 20,
    parameter int AXI_DATA_WIDTH  = 16,
    parameter int LEN_WIDTH       = 20,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                            axi_clk,
    input  logic                            axi_resetn,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]       cmd_addr,
    input  logic [LEN_WIDTH-1:0]            cmd_len,
    input  logic [AXI_DATA_WIDTH-1:0]       cmd_data,
    input  logic                            cmd_incr,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [AXI_ADDR_WIDTH-1:0]       axi_awaddr,
    output logic                            axi_awvalid,
    input  logic                            axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]       axi_wdata,
    output logic [(AXI_DATA_WIDTH+7)/8-1:0] axi_wstrb,
    output logic                            axi_wvalid,
    input  logic                            axi_wready,
    input  logic [1:0]                      axi_bresp,
    input  logic                            axi_bvalid,
    output logic                            axi_bready
`ifdef AXI_SRAM_FILL_STATS_EN
    ,
    output logic [31:0]                     fill_cycles,
    output logic [7:0]                      bresp_errs
`endif
);

    localparam logic [LEN_WIDTH-1:0] MAX_OUT = LEN_WIDTH'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                     state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0]  data_q, data_d;
    logic [LEN_WIDTH-1:0]       len_q, len_d;
    logic                       incr_q, incr_d;
    logic [LEN_WIDTH-1:0]       awCnt_q, awCnt_d;
    logic [LEN_WIDTH-1:0]       wCnt_q, wCnt_d;
    logic [LEN_WIDTH-1:0]       bCnt_q, bCnt_d;
    logic                       err_q, err_d;
    logic                       awValid_q, awValid_d;
    logic                       wValid_q, wValid_d;

    logic awHs;
    logic wHs;
    logic bHs;
    logic accept;

    assign cmd_ready   = (state_q == IDLE);
    assign busy        = (state_q == RUN) || (state_q == DRAIN);
    assign done        = (state_q == DONE);
    assign err         = err_q;
    assign axi_awaddr  = addr_q;
    assign axi_awvalid = awValid_q;
    assign axi_wdata   = data_q;
    assign axi_wstrb   = '1;
    assign axi_wvalid  = wValid_q;
    assign axi_bready  = busy;

    assign awHs   = awValid_q & axi_awready;
    assign wHs    = wValid_q & axi_wready;
    assign bHs    = axi_bvalid & axi_bready;
    assign accept = cmd_valid & cmd_ready;

    // State, command latches, beat counters and channel valids
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            len_q     <= '0;
            incr_q    <= 1'b0;
            awCnt_q   <= '0;
            wCnt_q    <= '0;
            bCnt_q    <= '0;
            err_q     <= 1'b0;
            awValid_q <= 1'b0;
            wValid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            len_q     <= len_d;
            incr_q    <= incr_d;
            awCnt_q   <= awCnt_d;
            wCnt_q    <= wCnt_d;
            bCnt_q    <= bCnt_d;
            err_q     <= err_d;
            awValid_q <= awValid_d;
            wValid_q  <= wValid_d;
        end
    end

    // Next state: the valids are computed from post-handshake counts so a new
    // beat follows a handshake back-to-back, and the exit test also uses the
    // post-handshake counts so a last response coinciding with the last
    // AW/W beat finishes the command without an extra cycle
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        len_d     = len_q;
        incr_d    = incr_q;
        awCnt_d   = awCnt_q;
        wCnt_d    = wCnt_q;
        bCnt_d    = bCnt_q;
        err_d     = err_q;
        awValid_d = 1'b0;
        wValid_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = cmd_addr;
                    data_d  = cmd_data;
                    len_d   = cmd_len;
                    incr_d  = cmd_incr;
                    awCnt_d = '0;
                    wCnt_d  = '0;
                    bCnt_d  = '0;
                    err_d   = 1'b0;
                    if (cmd_len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d   = RUN;
                        awValid_d = 1'b1;
                        wValid_d  = 1'b1;
                    end
                end
            end
            RUN, DRAIN: begin
                if (awHs) begin
                    awCnt_d = awCnt_q + LEN_WIDTH'(1);
                    addr_d  = addr_q + AXI_ADDR_WIDTH'(1);
                end
                if (wHs) begin
                    wCnt_d = wCnt_q + LEN_WIDTH'(1);
                    if (incr_q) begin
                        data_d = data_q + AXI_DATA_WIDTH'(1);
                    end
                end
                if (bHs) begin
                    bCnt_d = bCnt_q + LEN_WIDTH'(1);
                    if (axi_bresp != 2'b00) begin
                        err_d = 1'b1;
                    end
                end
                awValid_d = (awValid_q && !axi_awready) ||
                            ((awCnt_d < len_q) && ((awCnt_d - bCnt_d) < MAX_OUT));
                wValid_d  = (wValid_q && !axi_wready) ||
                            ((wCnt_d < len_q) && ((wCnt_d - bCnt_d) < MAX_OUT));
                if ((awCnt_d == len_q) && (wCnt_d == len_q)) begin
                    state_d = (bCnt_d == len_q) ? DONE : DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef AXI_SRAM_FILL_STATS_EN
    logic [31:0] fillCycles_q;
    logic [7:0]  brespErrs_q;

    assign fill_cycles = fillCycles_q;
    assign bresp_errs  = brespErrs_q;

    // Saturating busy-cycle and bad-response counters, cleared on accept
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            fillCycles_q <= '0;
            brespErrs_q  <= '0;
        end else if (accept) begin
            fillCycles_q <= '0;
            brespErrs_q  <= '0;
        end else if (busy) begin
            if (fillCycles_q != 32'hFFFF_FFFF) begin
                fillCycles_q <= fillCycles_q + 32'd1;
            end
            if (bHs && (axi_bresp != 2'b00) && (brespErrs_q != 8'hFF)) begin
                brespErrs_q <= brespErrs_q + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi_sram_fill_writer.sv
// Self-checking bench for axi_sram_fill_writer: a table of fill commands plus
// hand-written corner sequences and random commands, checked against a
// queue-based slave model and a plain arithmetic reference of the fill.
module tb_axi_sram_fill_writer;

    localparam int AW   = 20;
    localparam int DW   = 16;
    localparam int LW   = 20;
    localparam int MAXO = 4;

    logic          axi_clk = 1'b0;
    logic          axi_resetn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] cmd_data;
    logic          cmd_incr;
    logic          busy, done, err;
    logic [AW-1:0] axi_awaddr;
    logic          axi_awvalid, axi_awready;
    logic [DW-1:0] axi_wdata;
    logic [1:0]    axi_wstrb;
    logic          axi_wvalid, axi_wready;
    logic [1:0]    axi_bresp;
    logic          axi_bvalid, axi_bready;
`ifdef AXI_SRAM_FILL_STATS_EN
    logic [31:0]   fill_cycles;
    logic [7:0]    bresp_errs;
`endif

    axi_sram_fill_writer #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .LEN_WIDTH(LW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .axi_clk(axi_clk), .axi_resetn(axi_resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_data(cmd_data), .cmd_incr(cmd_incr),
        .busy(busy), .done(done), .err(err),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready)
`ifdef AXI_SRAM_FILL_STATS_EN
        , .fill_cycles(fill_cycles), .bresp_errs(bresp_errs)
`endif
    );

    always #5 axi_clk = ~axi_clk;

    typedef struct {
        logic [AW-1:0] addr;
        int            len;
        logic [DW-1:0] data;
        bit            incr;
        int            badIdx;
        bit            rnd;
        int            awHold;
        bit            expErr;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] awQ[$];
    logic [DW-1:0] wQ[$];
    int  bSent = 0, bAcc = 0, maxOut = 0, stabViol = 0, strbBad = 0;
    int  donePulses = 0, wBeforeAw = -1;
    int  knobBadIdx = -1, knobAwHold = 0;
    bit  knobRnd = 1'b0;
    int  badIdx = -1, awHold = 0;
    bit  rnd = 1'b0;
    bit  prevAwPend = 1'b0, prevWPend = 1'b0;
    logic [AW-1:0] prevAwAddr = '0;
    logic [DW-1:0] prevWData = '0;

    int   lat;
    bit   gotDone;
    logic errAtDone;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] expAddr(input vec_t v, input int i);
        return AW'(v.addr + AW'(i));
    endfunction

    function automatic logic [DW-1:0] expData(input vec_t v, input int i);
        return v.incr ? DW'(v.data + DW'(i)) : v.data;
    endfunction

    // Slave model and protocol monitor: records accepted beats, answers one
    // response per address/data pair, and tracks stability and outstanding depth
    initial begin : slave
        bit bAccNow;
        int pairs;
        int outNow;
        axi_awready = 1'b1;
        axi_wready  = 1'b1;
        axi_bvalid  = 1'b0;
        axi_bresp   = 2'b00;
        forever begin
            @(posedge axi_clk);
            if (!axi_resetn) begin
                awQ.delete();
                wQ.delete();
                bSent = 0;
                bAcc = 0;
                prevAwPend = 1'b0;
                prevWPend = 1'b0;
                awHold = 0;
                #1;
                axi_bvalid  = 1'b0;
                axi_bresp   = 2'b00;
                axi_awready = 1'b1;
                axi_wready  = 1'b1;
            end else begin
                if (prevAwPend && (!axi_awvalid || axi_awaddr != prevAwAddr)) stabViol++;
                if (prevWPend && (!axi_wvalid || axi_wdata != prevWData)) stabViol++;
                prevAwPend = axi_awvalid && !axi_awready;
                prevAwAddr = axi_awaddr;
                prevWPend  = axi_wvalid && !axi_wready;
                prevWData  = axi_wdata;
                if (cmd_valid && cmd_ready) begin
                    awQ.delete();
                    wQ.delete();
                    bSent = 0;
                    bAcc = 0;
                    maxOut = 0;
                    donePulses = 0;
                    wBeforeAw = -1;
                    badIdx = knobBadIdx;
                    rnd = knobRnd;
                    awHold = knobAwHold;
                end
                if (done) donePulses++;
                if (axi_awvalid && axi_awready) begin
                    if (awQ.size() == 0) wBeforeAw = wQ.size();
                    awQ.push_back(axi_awaddr);
                end
                if (axi_wvalid && axi_wready) begin
                    if (axi_wstrb != 2'b11) strbBad++;
                    wQ.push_back(axi_wdata);
                end
                bAccNow = axi_bvalid && axi_bready;
                if (bAccNow) bAcc++;
                outNow = ((awQ.size() > wQ.size()) ? awQ.size() : wQ.size()) - bAcc;
                if (outNow > maxOut) maxOut = outNow;
                #1;
                pairs = (awQ.size() < wQ.size()) ? awQ.size() : wQ.size();
                if (!axi_bvalid || bAccNow) begin
                    axi_bvalid = 1'b0;
                    if (bSent < pairs && (!rnd || $urandom_range(0, 1) == 1)) begin
                        axi_bresp  = (bSent == badIdx) ? 2'b10 : 2'b00;
                        axi_bvalid = 1'b1;
                        bSent++;
                    end
                end
                if (awHold > 0) begin
                    axi_awready = 1'b0;
                    awHold--;
                end else begin
                    axi_awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                axi_wready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    task automatic checkResetValues(input string tag);
        check({tag, " cmd_ready"}, cmd_ready, 1);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " err"}, err, 0);
        check({tag, " awvalid"}, axi_awvalid, 0);
        check({tag, " wvalid"}, axi_wvalid, 0);
        check({tag, " bready"}, axi_bready, 0);
        check({tag, " awaddr"}, axi_awaddr, 0);
        check({tag, " wdata"}, axi_wdata, 0);
    endtask

    // Present one command, wait for acceptance and for done (both bounded)
    task automatic applyStimulus(input vec_t v);
        bit accepted = 1'b0;
        knobBadIdx = v.badIdx;
        knobRnd    = v.rnd;
        knobAwHold = v.awHold;
        cmd_addr   = v.addr;
        cmd_len    = LW'(v.len);
        cmd_data   = v.data;
        cmd_incr   = v.incr;
        cmd_valid  = 1'b1;
        gotDone    = 1'b0;
        errAtDone  = 1'bx;
        lat        = -1;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(posedge axi_clk);
            if (cmd_ready) accepted = 1'b1;
            #1;
        end
        cmd_valid = 1'b0;
        if (!accepted) begin
            check("cmd accept timeout", 0, 1);
            return;
        end
        for (int i = 1; i <= 3000 && !gotDone; i++) begin
            @(posedge axi_clk);
            if (done) begin
                gotDone   = 1'b1;
                lat       = i;
                errAtDone = err;
            end
        end
        #1;
    endtask

    // Compare the recorded writes and completion status with the reference
    task automatic checkOutput(input vec_t v, input string tag);
        check({tag, " done seen"}, gotDone, 1);
        check({tag, " aw count"}, awQ.size(), v.len);
        check({tag, " w count"}, wQ.size(), v.len);
        for (int i = 0; i < v.len; i++) begin
            if (i < awQ.size()) check($sformatf("%s awaddr[%0d]", tag, i), awQ[i], expAddr(v, i));
            if (i < wQ.size())  check($sformatf("%s wdata[%0d]", tag, i), wQ[i], expData(v, i));
        end
        check({tag, " err at done"}, errAtDone, v.expErr);
        check({tag, " cmd_ready after done"}, cmd_ready, 1);
        repeat (2) @(posedge axi_clk);
        #1;
        check({tag, " done pulses"}, donePulses, 1);
        check({tag, " err held"}, err, v.expErr);
        check({tag, " busy idle"}, busy, 0);
        check({tag, " stability violations"}, stabViol, 0);
        check({tag, " wstrb not all ones"}, strbBad, 0);
        check({tag, " outstanding within limit"}, (maxOut <= MAXO), 1);
    endtask

    initial begin : main
        vec_t vecs[6];
        vec_t v;
        bit   reached;

        vecs[0] = '{addr: 20'hFFFFF, len: 3,  data: 16'hFFFE, incr: 1'b1, badIdx: -1, rnd: 1'b0, awHold: 0, expErr: 1'b0};
        vecs[1] = '{addr: 20'h00100, len: 5,  data: 16'h1234, incr: 1'b0, badIdx: 2,  rnd: 1'b0, awHold: 0, expErr: 1'b1};
        vecs[2] = '{addr: 20'h00200, len: 5,  data: 16'hAAAA, incr: 1'b1, badIdx: -1, rnd: 1'b0, awHold: 0, expErr: 1'b0};
        vecs[3] = '{addr: 20'h00300, len: 20, data: 16'h0001, incr: 1'b1, badIdx: -1, rnd: 1'b1, awHold: 0, expErr: 1'b0};
        vecs[4] = '{addr: 20'h00400, len: 1,  data: 16'h5555, incr: 1'b0, badIdx: 0,  rnd: 1'b0, awHold: 0, expErr: 1'b1};
        vecs[5] = '{addr: 20'hFFFF0, len: 17, data: 16'hFFF8, incr: 1'b1, badIdx: 16, rnd: 1'b1, awHold: 0, expErr: 1'b1};

        axi_resetn = 1'b0;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        cmd_data   = '0;
        cmd_incr   = 1'b0;
        repeat (3) @(posedge axi_clk);
        #1;
        checkResetValues("reset");
        axi_resetn = 1'b1;
        @(posedge axi_clk);
        #1;

        // Constant fill with an always-ready slave, completion latency bounded
        v = '{addr: 20'h00010, len: 4, data: 16'h0F00, incr: 1'b0, badIdx: -1, rnd: 1'b0, awHold: 0, expErr: 1'b0};
        applyStimulus(v);
        check("basic latency within 8", (lat >= 1 && lat <= 8), 1);
        checkOutput(v, "basic");

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], $sformatf("vec%0d", i));
        end

        // Zero-length command: done right after accept, no channel activity
        v = '{addr: 20'h00500, len: 0, data: 16'h1111, incr: 1'b0, badIdx: -1, rnd: 1'b0, awHold: 0, expErr: 1'b0};
        applyStimulus(v);
        check("len0 latency", lat, 1);
        checkOutput(v, "len0");

        // Address channel stalled: W runs ahead by exactly the outstanding limit
        v = '{addr: 20'h00600, len: 8, data: 16'h2000, incr: 1'b1, badIdx: -1, rnd: 1'b0, awHold: 10, expErr: 1'b0};
        applyStimulus(v);
        check("stall W beats before first AW", wBeforeAw, MAXO);
        checkOutput(v, "stall");

        // Reset mid-command aborts immediately, then a fresh command runs
        knobBadIdx = -1;
        knobRnd    = 1'b0;
        knobAwHold = 0;
        cmd_addr   = 20'h00700;
        cmd_len    = LW'(6);
        cmd_data   = 16'h7000;
        cmd_incr   = 1'b1;
        cmd_valid  = 1'b1;
        reached    = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(posedge axi_clk);
            #2;
            cmd_valid = cmd_valid && !busy;
            if (awQ.size() >= 2) reached = 1'b1;
        end
        cmd_valid = 1'b0;
        check("reset test reached two writes", reached, 1);
        axi_resetn = 1'b0;
        #1;
        checkResetValues("mid reset");
        repeat (2) @(posedge axi_clk);
        #1;
        axi_resetn = 1'b1;
        @(posedge axi_clk);
        #1;
        v = '{addr: 20'h00800, len: 6, data: 16'h3000, incr: 1'b0, badIdx: -1, rnd: 1'b0, awHold: 0, expErr: 1'b0};
        applyStimulus(v);
        checkOutput(v, "after reset");

        // Random commands against the same reference
        for (int n = 0; n < 12; n++) begin
            v.len    = $urandom_range(0, 24);
            v.addr   = ($urandom_range(0, 3) == 0) ? AW'(20'hFFFFF - AW'($urandom_range(0, 8))) : AW'($urandom);
            v.data   = DW'($urandom);
            v.incr   = 1'($urandom_range(0, 1));
            v.badIdx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, v.len)) : -1;
            v.rnd    = 1'b1;
            v.awHold = 0;
            v.expErr = (v.badIdx >= 0) && (v.badIdx < v.len);
            applyStimulus(v);
            checkOutput(v, $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_sram_fill_writer.md
Name: axi_sram_fill_writer

Overview:
Command-driven AXI-Lite write master that sits directly upstream of the AXI SRAM controller's write channels. It fills a contiguous SRAM region with a constant or incrementing 16-bit word, e.g. framebuffer clear, solid fill or test gradient. It replaces the fixed boot-time pattern writer. It keeps up to MAX_OUTSTANDING writes in flight and reports completion and any bad write responses.

Parameters:
AXI_ADDR_WIDTH, 20, word address width of the AXI-Lite write address and of cmd_addr.
AXI_DATA_WIDTH, 16, data width; wstrb width is (AXI_DATA_WIDTH+7)/8.
LEN_WIDTH, 20, width of cmd_len (word count).
MAX_OUTSTANDING, 4, maximum accepted-AW beats without a B response; power of two, 1..16.

Ports:
axi_clk  in  1  single clock for all logic.
axi_resetn  in  1  asynchronous active-low reset.
cmd_valid  in  1  fill command present.
cmd_ready  out  1  block can accept a command; high only in IDLE.
cmd_addr  in  AXI_ADDR_WIDTH  first word address.
cmd_len  in  LEN_WIDTH  number of words to write.
cmd_data  in  AXI_DATA_WIDTH  first data word.
cmd_incr  in  1  1 = data increments by 1 per word; 0 = constant.
busy  out  1  command in progress (RUN or DRAIN).
done  out  1  one-cycle pulse when a command completes.
err  out  1  any bresp != 0 seen during the last command; valid when done is high, held until the next accept.
axi_awaddr  out  AXI_ADDR_WIDTH  write address.
axi_awvalid  out  1  write address valid.
axi_awready  in  1  write address ready.
axi_wdata  out  AXI_DATA_WIDTH  write data.
axi_wstrb  out  (AXI_DATA_WIDTH+7)/8  always all ones.
axi_wvalid  out  1  write data valid.
axi_wready  in  1  write data ready.
axi_bresp  in  2  write response.
axi_bvalid  in  1  write response valid.
axi_bready  out  1  write response ready.

Behaviour:
- Reset (async assert, sync release): state IDLE. cmd_ready=1, busy=0, done=0, err=0, awvalid=0, wvalid=0, bready=0. awaddr, wdata and all counters are 0.
- Accept: in IDLE, cmd_valid & cmd_ready latches addr, len, data and incr, and clears err.
  - len==0: go to DONE.
  - Otherwise go to RUN. awvalid and wvalid rise the cycle after accept.
- Counters: aw_cnt and w_cnt count accepted beats; b_cnt counts accepted responses. All are LEN_WIDTH wide.
- AW and W channels are independent; either may lead the other.
- AW issue: awvalid is asserted while aw_cnt < len and (aw_cnt - b_cnt) < MAX_OUTSTANDING.
  - Once raised, awvalid and awaddr hold stable until awready.
  - On handshake, awaddr increments by 1, wrapping modulo 2^AXI_ADDR_WIDTH.
- W issue: wvalid is asserted while w_cnt < len and (w_cnt - b_cnt) < MAX_OUTSTANDING, with the same stability rule.
  - On handshake, wdata increments by 1 (wraps 0xFFFF -> 0x0000) if incr, else holds.
- A new beat may be presented on the cycle following a handshake, giving a throughput of 1 word/cycle when the slave is always ready.
- bready=1 in RUN and DRAIN, 0 otherwise. Each bvalid & bready increments b_cnt. bresp != 0 sets err (sticky).
- RUN -> DRAIN when aw_cnt==len and w_cnt==len.
- DRAIN -> DONE when b_cnt==len. This includes a final response arriving on the same cycle as the last AW/W handshake.
- DONE: done=1 for exactly one cycle, then IDLE with cmd_ready=1. No command can be accepted in the DONE cycle.
- busy = (state==RUN | state==DRAIN).
- cmd_valid while busy is ignored; the command must be held by the source until cmd_ready.
- Simultaneous AW handshake, W handshake and B accept in one cycle must all update their counters correctly.
- bvalid outside RUN/DRAIN is not accepted (bready=0).
- Reset asserted mid-command aborts immediately to reset values. Any in-flight slave transactions are the slave's concern, since it shares the reset.

Optional Feature:
Macro AXI_SRAM_FILL_STATS_EN.
- Defined: adds output fill_cycles [31:0].
  - Clears on command accept, increments every cycle while busy, saturates at 0xFFFFFFFF.
  - Holds its value after done until the next accept.
  - Adds output bresp_errs [7:0]: count of nonzero bresp in the current command, saturating at 255, same clear rule.
- Not defined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Always-ready slave, cmd addr=0x00010, len=4, data=0x0F00, incr=0 -> four writes to 0x10..0x13, each with wdata 0x0F00 and wstrb 2'b11. done pulses once, err=0. With bvalid one cycle after each AW/W, done occurs within 8 cycles of accept.
- len=3, data=0xFFFE, incr=1, addr=0xFFFFF -> addresses 0xFFFFF, 0x00000, 0x00001; data 0xFFFE, 0xFFFF, 0x0000.
- awready held low for 10 cycles while wready=1, len=8 -> exactly 4 W beats issue, then W stalls. awaddr and awvalid stay stable across the stall. All 8 writes complete, each address paired with its data in order.
- len=0 -> no AW/W activity, done one cycle after accept, cmd_ready returns the next cycle.
- len=5 with bresp=2'b10 on the 3rd response only -> all 5 writes still issued, err=1 at done; the next command with good responses gives err=0.
- Reset pulsed after 2 of 6 writes -> all outputs at reset values asynchronously. A new command after release runs cleanly from its own cmd_addr.
